i2c_txn_arbiter: RTL and testbench

- Transaction scheduler in front of the I2C master FSM.
- Accepts transaction commands from two requesters (MCU and DMA), arbitrates round-robin and drives the FSM's enable, rw and repeat-start controls.
- Counts completed bytes, detects NACK/stop/timeout, and returns a per-command completion status to the owning requester.
- Supports chained transactions (write-then-read) through repeated START without releasing the bus.

---
 rtl/i2c_pkg.sv | 29 ++
 rtl/i2c_txn_arbiter_if.sv | 36 +++
 rtl/i2c_rr_arb2.sv | 21 ++
 rtl/i2c_txn_arbiter.sv | 242 ++++++++++++++++++++++++
 tb/tb_i2c_txn_arbiter.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared types for the I2C transaction scheduler: FSM states, completion codes
// and requester indices.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_LAUNCH,
    ST_ACTIVE,
    ST_RSTART,
    ST_WAIT_STOP,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_NACK    = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_ZLEN    = 2'b11
  } err_e;

  localparam logic REQ_MCU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  function automatic logic other_req(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/i2c_txn_arbiter_if.sv
// Requester command/response and I2C master FSM control signals of the
// transaction scheduler; slave is the scheduler's view, master the environment's.
interface i2c_txn_arbiter_if #(
  parameter int unsigned LEN_W = 4
);
  logic [1:0]         req_valid_i;
  logic [1:0]         req_ready_o;
  logic [1:0]         req_rw_i;
  logic [13:0]        req_addr_i;
  logic [2*LEN_W-1:0] req_len_i;
  logic [1:0]         req_chain_i;
  logic               m_enable_o;
  logic               m_rw_o;
  logic               m_repeat_start_o;
  logic [6:0]         m_addr_o;
  logic               m_byte_done_i;
  logic               m_nack_i;
  logic               m_stop_i;
  logic               resp_valid_o;
  logic               resp_id_o;
  logic [1:0]         resp_err_o;

  modport slave (
    input  req_valid_i, req_rw_i, req_addr_i, req_len_i, req_chain_i,
           m_byte_done_i, m_nack_i, m_stop_i,
    output req_ready_o, m_enable_o, m_rw_o, m_repeat_start_o, m_addr_o,
           resp_valid_o, resp_id_o, resp_err_o
  );

  modport master (
    output req_valid_i, req_rw_i, req_addr_i, req_len_i, req_chain_i,
           m_byte_done_i, m_nack_i, m_stop_i,
    input  req_ready_o, m_enable_o, m_rw_o, m_repeat_start_o, m_addr_o,
           resp_valid_o, resp_id_o, resp_err_o
  );
endinterface

// File: rtl/i2c_rr_arb2.sv
// Two-way round-robin picker: the requester named by ptr_i wins a tie.
module i2c_rr_arb2
  import i2c_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    if (ptr_i == REQ_MCU) begin
      if (valid_i[0])      gnt_o = 2'b01;
      else if (valid_i[1]) gnt_o = 2'b10;
    end else begin
      if (valid_i[1])      gnt_o = 2'b10;
      else if (valid_i[0]) gnt_o = 2'b01;
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Schedules MCU/DMA I2C transactions onto the master FSM, tracks bytes and
// timeouts, and returns one completion status per accepted command.
module i2c_txn_arbiter
  import i2c_pkg::*;
#(
  parameter int unsigned LEN_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned TO_W        = 12
) (
  input logic               i2c_core_clk_i,
  input logic               reset_ni,
  i2c_txn_arbiter_if.slave  bus
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  err_e              err_q, err_d;
  logic              ptr_q, ptr_d;
  logic              id_q, id_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              chain_q, chain_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [1:0]        ready_q, ready_d;
  logic              en_q, en_d;
  logic              rw_q, rw_d;
  logic              rs_q, rs_d;
  logic [6:0]        addr_q, addr_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_id_q, resp_id_d;
  logic [1:0]        resp_err_q, resp_err_d;

  logic [1:0]        gnt;
  logic              sel_valid, sel_rw, sel_chain;
  logic [6:0]        sel_addr;
  logic [LEN_W-1:0]  sel_len;
  logic [LEN_W-1:0]  cnt_inc;
  logic [TO_W-1:0]   to_inc;
  logic              to_hit;

  i2c_rr_arb2 u_arb (
    .valid_i (bus.req_valid_i),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt)
  );

  always_comb begin
    sel_valid = bus.req_valid_i[id_q];
    sel_rw    = bus.req_rw_i[id_q];
    sel_chain = bus.req_chain_i[id_q];
    sel_addr  = id_q ? bus.req_addr_i[13:7] : bus.req_addr_i[6:0];
    sel_len   = id_q ? bus.req_len_i[2*LEN_W-1:LEN_W] : bus.req_len_i[LEN_W-1:0];
    cnt_inc   = cnt_q + LEN_W'(1);
    to_inc    = to_q + TO_W'(1);
    to_hit    = (to_q == TO_LAST);
  end

  always_comb begin
    state_d      = state_q;
    err_d        = err_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    chain_d      = chain_q;
    to_d         = to_q;
    ready_d      = '0;
    en_d         = en_q;
    rw_d         = rw_q;
    rs_d         = rs_q;
    addr_d       = addr_q;
    resp_valid_d = 1'b0;
    resp_id_d    = resp_id_q;
    resp_err_d   = resp_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (|bus.req_valid_i) begin
          id_d    = gnt[1];
          ready_d = gnt;
          state_d = ST_GRANT;
        end
      end

      ST_GRANT: begin
        len_d   = sel_len;
        chain_d = sel_chain;
        cnt_d   = '0;
        to_d    = '0;
        if (sel_len == '0) begin
          err_d        = ERR_ZLEN;
          resp_valid_d = 1'b1;
          resp_id_d    = id_q;
          resp_err_d   = ERR_ZLEN;
          state_d      = ST_RESP;
        end else begin
          err_d   = ERR_OK;
          en_d    = 1'b1;
          rw_d    = sel_rw;
          addr_d  = sel_addr;
          state_d = ST_LAUNCH;
        end
      end

      ST_LAUNCH: state_d = ST_ACTIVE;

      ST_ACTIVE: begin
        // A byte completion takes precedence over a timeout landing on the same cycle.
        if (bus.m_byte_done_i) begin
          to_d  = '0;
          cnt_d = cnt_inc;
          if (bus.m_nack_i) begin
            err_d   = ERR_NACK;
            en_d    = 1'b0;
            state_d = ST_WAIT_STOP;
          end else if (cnt_inc == len_q) begin
            if (chain_q) begin
              rs_d    = 1'b1;
              state_d = ST_RSTART;
            end else begin
              en_d    = 1'b0;
              state_d = ST_WAIT_STOP;
            end
          end
        end else if (to_hit) begin
          err_d   = ERR_TIMEOUT;
          en_d    = 1'b0;
          to_d    = '0;
          state_d = ST_WAIT_STOP;
        end else begin
          to_d = to_inc;
        end
      end

      ST_RSTART: begin
        // Bus stays owned; only the chaining requester may continue.
        if (sel_valid) begin
          ready_d      = id_q ? 2'b10 : 2'b01;
          len_d        = sel_len;
          chain_d      = sel_chain;
          rw_d         = sel_rw;
          addr_d       = sel_addr;
          rs_d         = 1'b0;
          cnt_d        = '0;
          to_d         = '0;
          resp_valid_d = 1'b1;
          resp_id_d    = id_q;
          resp_err_d   = ERR_OK;
          if (sel_len == '0) begin
            err_d   = ERR_ZLEN;
            en_d    = 1'b0;
            state_d = ST_WAIT_STOP;
          end else begin
            err_d   = ERR_OK;
            state_d = ST_ACTIVE;
          end
        end else if (to_hit) begin
          err_d   = ERR_TIMEOUT;
          en_d    = 1'b0;
          rs_d    = 1'b0;
          to_d    = '0;
          state_d = ST_WAIT_STOP;
        end else begin
          to_d = to_inc;
        end
      end

      ST_WAIT_STOP: begin
        if (bus.m_stop_i) begin
          resp_valid_d = 1'b1;
          resp_id_d    = id_q;
          resp_err_d   = err_q;
          state_d      = ST_RESP;
        end else if (to_hit) begin
          err_d        = ERR_TIMEOUT;
          resp_valid_d = 1'b1;
          resp_id_d    = id_q;
          resp_err_d   = ERR_TIMEOUT;
          state_d      = ST_RESP;
        end else begin
          to_d = to_inc;
        end
      end

      ST_RESP: begin
        ptr_d   = other_req(id_q);
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i2c_core_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= ST_IDLE;
      err_q        <= ERR_OK;
      ptr_q        <= REQ_MCU;
      id_q         <= REQ_MCU;
      len_q        <= '0;
      cnt_q        <= '0;
      chain_q      <= 1'b0;
      to_q         <= '0;
      ready_q      <= '0;
      en_q         <= 1'b0;
      rw_q         <= 1'b0;
      rs_q         <= 1'b0;
      addr_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_err_q   <= '0;
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      chain_q      <= chain_d;
      to_q         <= to_d;
      ready_q      <= ready_d;
      en_q         <= en_d;
      rw_q         <= rw_d;
      rs_q         <= rs_d;
      addr_q       <= addr_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.req_ready_o      = ready_q;
  assign bus.m_enable_o       = en_q;
  assign bus.m_rw_o           = rw_q;
  assign bus.m_repeat_start_o = rs_q;
  assign bus.m_addr_o         = addr_q;
  assign bus.resp_valid_o     = resp_valid_q;
  assign bus.resp_id_o        = resp_id_q;
  assign bus.resp_err_o       = resp_err_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter: hand-computed cycle-exact expectations
// for grant order, byte counting, NACK, chaining, timeout and reset abort.
module tb_i2c_txn_arbiter;

  localparam int unsigned LEN_W = 4;

  logic clk;
  logic rst_n;
  int   vectors     = 0;
  int   miscompares = 0;
  int   resp_seen   = 0;

  i2c_txn_arbiter_if #(.LEN_W(LEN_W)) bus ();

  i2c_txn_arbiter #(
    .LEN_W       (LEN_W),
    .TIMEOUT_CYC (32),
    .TO_W        (6)
  ) dut (
    .i2c_core_clk_i (clk),
    .reset_ni       (rst_n),
    .bus            (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.resp_valid_o === 1'b1) resp_seen++;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int unsigned id, input logic rw, input logic [6:0] addr,
                         input logic [LEN_W-1:0] len, input logic chain);
    bus.req_rw_i[id]               = rw;
    bus.req_addr_i[id*7 +: 7]      = addr;
    bus.req_len_i[id*LEN_W +: LEN_W] = len;
    bus.req_chain_i[id]            = chain;
  endtask

  task automatic byte_pulse(input logic nack);
    bus.m_byte_done_i = 1'b1;
    bus.m_nack_i      = nack;
    step();
    bus.m_byte_done_i = 1'b0;
    bus.m_nack_i      = 1'b0;
  endtask

  task automatic stop_pulse();
    bus.m_stop_i = 1'b1;
    step();
    bus.m_stop_i = 1'b0;
  endtask

  task automatic chk_resp(input string tag, input logic id, input logic [1:0] err);
    chk({tag, "_valid"}, bus.resp_valid_o, 1'b1);
    chk({tag, "_id"},    bus.resp_id_o,    id);
    chk({tag, "_err"},   bus.resp_err_o,   err);
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.req_valid_i   = '0;
    bus.req_rw_i      = '0;
    bus.req_addr_i    = '0;
    bus.req_len_i     = '0;
    bus.req_chain_i   = '0;
    bus.m_byte_done_i = 1'b0;
    bus.m_nack_i      = 1'b0;
    bus.m_stop_i      = 1'b0;
    repeat (3) step();

    chk("rst_ready", bus.req_ready_o, 2'b00);
    chk("rst_en",    bus.m_enable_o, 1'b0);
    chk("rst_rw",    bus.m_rw_o, 1'b0);
    chk("rst_rs",    bus.m_repeat_start_o, 1'b0);
    chk("rst_addr",  bus.m_addr_o, 7'h00);
    chk("rst_rv",    bus.resp_valid_o, 1'b0);
    chk("rst_rid",   bus.resp_id_o, 1'b0);
    chk("rst_rerr",  bus.resp_err_o, 2'b00);
    rst_n = 1'b1;
    step();

    // MCU write 0x50, three bytes
    set_req(0, 1'b0, 7'h50, 4'd3, 1'b0);
    bus.req_valid_i = 2'b01;
    step();
    chk("t1_ready", bus.req_ready_o, 2'b01);
    chk("t1_en_grant", bus.m_enable_o, 1'b0);
    bus.req_valid_i = 2'b00;
    step();
    chk("t1_en_launch", bus.m_enable_o, 1'b1);
    chk("t1_addr", bus.m_addr_o, 7'h50);
    chk("t1_rw", bus.m_rw_o, 1'b0);
    chk("t1_ready_pulse", bus.req_ready_o, 2'b00);
    step();
    byte_pulse(1'b0);
    byte_pulse(1'b0);
    chk("t1_en_b2", bus.m_enable_o, 1'b1);
    byte_pulse(1'b0);
    chk("t1_en_b3", bus.m_enable_o, 1'b0);
    chk("t1_no_resp_before_stop", bus.resp_valid_o, 1'b0);
    stop_pulse();
    chk_resp("t1_resp", 1'b0, 2'b00);
    step();
    chk("t1_resp_pulse", bus.resp_valid_o, 1'b0);

    // Simultaneous requests after reset: MCU, then DMA, then MCU again
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    set_req(0, 1'b0, 7'h11, 4'd1, 1'b0);
    set_req(1, 1'b0, 7'h22, 4'd1, 1'b0);
    bus.req_valid_i = 2'b11;
    step();
    chk("t2_first_grant", bus.req_ready_o, 2'b01);
    bus.req_valid_i = 2'b10;
    step();
    chk("t2_first_addr", bus.m_addr_o, 7'h11);
    step();
    byte_pulse(1'b0);
    stop_pulse();
    chk_resp("t2_resp_a", 1'b0, 2'b00);
    step();
    step();
    chk("t2_second_grant", bus.req_ready_o, 2'b10);
    bus.req_valid_i = 2'b00;
    step();
    chk("t2_second_addr", bus.m_addr_o, 7'h22);
    step();
    byte_pulse(1'b0);
    stop_pulse();
    chk_resp("t2_resp_b", 1'b1, 2'b00);
    step();
    bus.req_valid_i = 2'b11;
    step();
    chk("t2_third_grant", bus.req_ready_o, 2'b01);
    bus.req_valid_i = 2'b00;
    step();
    step();
    byte_pulse(1'b0);
    stop_pulse();
    chk_resp("t2_resp_c", 1'b0, 2'b00);
    step();

    // DMA read len 4, NACK on second byte
    set_req(1, 1'b1, 7'h3A, 4'd4, 1'b0);
    bus.req_valid_i = 2'b10;
    step();
    chk("t3_grant", bus.req_ready_o, 2'b10);
    bus.req_valid_i = 2'b00;
    step();
    chk("t3_rw", bus.m_rw_o, 1'b1);
    chk("t3_addr", bus.m_addr_o, 7'h3A);
    step();
    byte_pulse(1'b0);
    chk("t3_en_b1", bus.m_enable_o, 1'b1);
    byte_pulse(1'b1);
    chk("t3_en_nack", bus.m_enable_o, 1'b0);
    stop_pulse();
    chk_resp("t3_resp", 1'b1, 2'b01);
    step();

    // MCU write len 1 chained into MCU read len 2; DMA (len 0) waits
    set_req(0, 1'b0, 7'h48, 4'd1, 1'b1);
    set_req(1, 1'b0, 7'h33, 4'd0, 1'b0);
    bus.req_valid_i = 2'b11;
    step();
    chk("t4_grant", bus.req_ready_o, 2'b01);
    bus.req_valid_i = 2'b10;
    step();
    step();
    byte_pulse(1'b0);
    chk("t4_rs", bus.m_repeat_start_o, 1'b1);
    chk("t4_en_rs", bus.m_enable_o, 1'b1);
    step();
    chk("t4_dma_locked", bus.req_ready_o, 2'b00);
    chk("t4_rs_hold", bus.m_repeat_start_o, 1'b1);
    set_req(0, 1'b1, 7'h48, 4'd2, 1'b0);
    bus.req_valid_i = 2'b11;
    step();
    chk("t4_regrant", bus.req_ready_o, 2'b01);
    chk_resp("t4_resp_first", 1'b0, 2'b00);
    chk("t4_rs_drop", bus.m_repeat_start_o, 1'b0);
    chk("t4_rw_read", bus.m_rw_o, 1'b1);
    bus.req_valid_i = 2'b10;
    byte_pulse(1'b0);
    chk("t4_resp_pulse", bus.resp_valid_o, 1'b0);
    chk("t4_en_b1", bus.m_enable_o, 1'b1);
    byte_pulse(1'b0);
    chk("t4_en_b2", bus.m_enable_o, 1'b0);
    stop_pulse();
    chk_resp("t4_resp_second", 1'b0, 2'b00);
    step();
    step();
    chk("t4_zlen_grant", bus.req_ready_o, 2'b10);
    bus.req_valid_i = 2'b00;
    step();
    chk_resp("t4_zlen_resp", 1'b1, 2'b11);
    chk("t4_zlen_no_en", bus.m_enable_o, 1'b0);
    step();

    // MCU command with no byte completions: timeout in ACTIVE and WAIT_STOP
    set_req(0, 1'b0, 7'h2C, 4'd2, 1'b0);
    bus.req_valid_i = 2'b01;
    step();
    bus.req_valid_i = 2'b00;
    step();
    chk("t5_en_launch", bus.m_enable_o, 1'b1);
    repeat (32) step();
    chk("t5_en_last_cycle", bus.m_enable_o, 1'b1);
    step();
    chk("t5_en_timeout", bus.m_enable_o, 1'b0);
    repeat (31) step();
    chk("t5_no_resp_early", bus.resp_valid_o, 1'b0);
    step();
    chk_resp("t5_resp", 1'b0, 2'b10);
    step();

    // DMA: byte completion on the timeout cycle wins, twice
    set_req(1, 1'b1, 7'h19, 4'd2, 1'b0);
    bus.req_valid_i = 2'b10;
    step();
    chk("t6_grant", bus.req_ready_o, 2'b10);
    bus.req_valid_i = 2'b00;
    step();
    repeat (32) step();
    byte_pulse(1'b0);
    chk("t6_tie_b1", bus.m_enable_o, 1'b1);
    repeat (31) step();
    chk("t6_to_cleared", bus.m_enable_o, 1'b1);
    byte_pulse(1'b0);
    chk("t6_tie_b2", bus.m_enable_o, 1'b0);
    stop_pulse();
    chk_resp("t6_resp", 1'b1, 2'b00);
    step();

    // Reset during ACTIVE: outputs clear at once, no response
    set_req(0, 1'b0, 7'h50, 4'd3, 1'b0);
    bus.req_valid_i = 2'b01;
    step();
    bus.req_valid_i = 2'b00;
    step();
    step();
    byte_pulse(1'b0);
    chk("t7_en_active", bus.m_enable_o, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t7_async_en", bus.m_enable_o, 1'b0);
    chk("t7_async_addr", bus.m_addr_o, 7'h00);
    chk("t7_async_ready", bus.req_ready_o, 2'b00);
    chk("t7_async_rv", bus.resp_valid_o, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    step();
    stop_pulse();
    repeat (3) step();
    chk("t7_no_resp", bus.resp_valid_o, 1'b0);
    set_req(0, 1'b0, 7'h00, 4'd0, 1'b0);
    bus.req_valid_i = 2'b01;
    step();
    chk("t7_post_grant", bus.req_ready_o, 2'b01);
    bus.req_valid_i = 2'b00;
    step();
    chk_resp("t7_post_zlen", 1'b0, 2'b11);
    step();
    step();

    chk("total_resp_pulses", resp_seen, 11);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
